// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction-fetch sequencer for the 5-stage MIPS pipeline. It owns the PC,
// drives the combinational instruction ROM address and registers the IF/ID
// latch. It applies hazard-unit stall/flush and ID/EX redirects, and parks
// fetch when the program reaches its terminal "j self" loop.
//
// Ports
//   clk            in   1   system clock, rising edge
//   reset          in   1   synchronous, active-high reset
//   stall_i        in   1   hold PC and IF/ID contents
//   flush_i        in   1   load bubble into IF/ID
//   redirect_i     in   1   taken branch/jump; load redirect_pc_i
//   redirect_pc_i  in   32  redirect target (bits [1:0] ignored)
//   imem_addr_o    out  32  InstMEM address (combinational)
//   imem_data_i    in   32  InstMEM instruction (same cycle)
//   if_pc_o        out  32  IF/ID PC
//   if_pc4_o       out  32  IF/ID PC + 4
//   if_inst_o      out  32  IF/ID instruction (0 when invalid)
//   if_valid_o     out  1   IF/ID holds a real instruction
//   halted_o       out  1   fetch parked on j-self loop
//   fetch_count_o  out  32  saturating count of valid captures
//
// Optional feature macro: DBG_PORT_EN
//   Adds a debug read port sharing the ROM while fetch is halted or stalled:
//   dbg_req_i, dbg_addr_i[31:0], dbg_gnt_o, dbg_data_o[31:0], dbg_valid_o.
//
// State table
//   ST_BOOT | one idle cycle after reset, nothing captured
//   ST_RUN  | normal fetch, honours redirect > stall > normal
//   ST_HALT | parked on j-self, IF/ID bubbles, PC and count frozen
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic        halted_o,
  output logic [31:0] fetch_count_o
`ifdef DBG_PORT_EN
  ,
  input  logic        dbg_req_i,
  input  logic [31:0] dbg_addr_i,
  output logic        dbg_gnt_o,
  output logic [31:0] dbg_data_o,
  output logic        dbg_valid_o
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] if_pc, if_pc_nxt;
  logic [31:0] if_pc4, if_pc4_nxt;
  logic [31:0] if_inst, if_inst_nxt;
  logic        if_valid, if_valid_nxt;
  logic [31:0] fetch_count, fetch_count_nxt;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic [31:0] count_inc;
  logic        jump_self;
  logic        unused_redirect_lsb;

  assign pc_plus4            = pc + 32'd4;
  assign redirect_tgt        = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];
  assign count_inc           = (fetch_count == 32'hFFFF_FFFF) ? fetch_count : fetch_count + 32'd1;

  // J-type with opcode 2 whose pseudo-direct target equals its own address.
  assign jump_self = (imem_data_i[31:26] == 6'b000010) &&
                     ({pc[31:28], imem_data_i[25:0], 2'b00} == pc);

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    if_pc_nxt       = if_pc;
    if_pc4_nxt      = if_pc4;
    if_inst_nxt     = if_inst;
    if_valid_nxt    = if_valid;
    fetch_count_nxt = fetch_count;

    case (state)
      ST_BOOT: begin
        state_nxt = ST_RUN;
      end

      ST_RUN: begin
        if (redirect_i) begin
          pc_nxt       = redirect_tgt;
          if_pc_nxt    = 32'd0;
          if_pc4_nxt   = 32'd0;
          if_inst_nxt  = 32'd0;
          if_valid_nxt = 1'b0;
        end else if (stall_i) begin
          if (flush_i) begin
            if_pc_nxt    = 32'd0;
            if_pc4_nxt   = 32'd0;
            if_inst_nxt  = 32'd0;
            if_valid_nxt = 1'b0;
          end
        end else if (flush_i) begin
          pc_nxt       = pc_plus4;
          if_pc_nxt    = 32'd0;
          if_pc4_nxt   = 32'd0;
          if_inst_nxt  = 32'd0;
          if_valid_nxt = 1'b0;
        end else begin
          if_pc_nxt       = pc;
          if_pc4_nxt      = pc_plus4;
          if_inst_nxt     = imem_data_i;
          if_valid_nxt    = 1'b1;
          fetch_count_nxt = count_inc;
          if (jump_self) begin
            // The jump itself is delivered downstream; only the PC parks.
            state_nxt = ST_HALT;
          end else begin
            pc_nxt = pc_plus4;
          end
        end
      end

      ST_HALT: begin
        if_pc_nxt    = 32'd0;
        if_pc4_nxt   = 32'd0;
        if_inst_nxt  = 32'd0;
        if_valid_nxt = 1'b0;
        // A redirect back onto the parked loop would just re-halt; ignore it.
        if (redirect_i && (redirect_tgt != pc)) begin
          pc_nxt    = redirect_tgt;
          state_nxt = ST_RUN;
        end
      end

      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      if_pc       <= 32'd0;
      if_pc4      <= 32'd0;
      if_inst     <= 32'd0;
      if_valid    <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_pc       <= if_pc_nxt;
      if_pc4      <= if_pc4_nxt;
      if_inst     <= if_inst_nxt;
      if_valid    <= if_valid_nxt;
      fetch_count <= fetch_count_nxt;
    end
  end

  assign if_pc_o       = if_pc;
  assign if_pc4_o      = if_pc4;
  assign if_inst_o     = if_inst;
  assign if_valid_o    = if_valid;
  assign halted_o      = (state == ST_HALT);
  assign fetch_count_o = fetch_count;

`ifdef DBG_PORT_EN
  logic dbg_gnt;
  logic unused_dbg_lsb;

  // The ROM is only lent out when fetch cannot be capturing this cycle.
  assign dbg_gnt        = dbg_req_i && ((state == ST_HALT) || stall_i) && !redirect_i && !reset;
  assign dbg_gnt_o      = dbg_gnt;
  assign unused_dbg_lsb = ^dbg_addr_i[1:0];
  assign imem_addr_o    = dbg_gnt ? {dbg_addr_i[31:2], 2'b00} : pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_data_o  <= 32'd0;
      dbg_valid_o <= 1'b0;
    end else begin
      dbg_valid_o <= dbg_gnt;
      if (dbg_gnt) begin
        dbg_data_o <= imem_data_i;
      end
    end
  end
`else
  assign imem_addr_o = pc;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] if_pc_o, if_pc4_o, if_inst_o, fetch_count_o;
  logic        if_valid_o, halted_o;
`ifdef DBG_PORT_EN
  logic        dbg_req_i = 1'b0;
  logic [31:0] dbg_addr_i = 32'd0;
  logic        dbg_gnt_o, dbg_valid_o;
  logic [31:0] dbg_data_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .if_pc_o(if_pc_o), .if_pc4_o(if_pc4_o), .if_inst_o(if_inst_o),
    .if_valid_o(if_valid_o), .halted_o(halted_o), .fetch_count_o(fetch_count_o)
`ifdef DBG_PORT_EN
    , .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_data_o(dbg_data_o), .dbg_valid_o(dbg_valid_o)
`endif
  );

  // Small instruction ROM: a few fixed words, everything else an addiu-like
  // word tagged with the low address bits (never a jump).
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0040_0000: rom = 32'h2008_0000;
      32'h0040_0130: rom = 32'h2008_0001;
      32'h0040_01C8: rom = 32'h0810_0072;
      default:       rom = 32'h2400_0000 | {16'h0000, a[15:0]};
    endcase
  endfunction

  assign imem_data_i = rom(imem_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    stall_i = s; flush_i = f; redirect_i = r; redirect_pc_i = rpc;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_inst;
    logic        e_valid;
    logic [31:0] e_cnt;
    logic        e_halt;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            stall flush redir rpc            addr           pc             pc4            inst           v     cnt        halt
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 32'h2008_0000, 1'b1, 32'd1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0040_0008, 32'h0040_0004, 32'h0040_0008, 32'h2400_0004, 1'b1, 32'd2, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0040_0131,  32'h0040_0130, 32'h0,         32'h0,         32'h0,         1'b0, 32'd2, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0040_0134, 32'h0040_0130, 32'h0040_0134, 32'h2008_0001, 1'b1, 32'd3, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,          32'h0040_0134, 32'h0040_0130, 32'h0040_0134, 32'h2008_0001, 1'b1, 32'd3, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,          32'h0040_0134, 32'h0040_0130, 32'h0040_0134, 32'h2008_0001, 1'b1, 32'd3, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,          32'h0040_0134, 32'h0040_0130, 32'h0040_0134, 32'h2008_0001, 1'b1, 32'd3, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,          32'h0040_0134, 32'h0,         32'h0,         32'h0,         1'b0, 32'd3, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h0040_0200,  32'h0040_0200, 32'h0,         32'h0,         32'h0,         1'b0, 32'd3, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,          32'h0040_0204, 32'h0,         32'h0,         32'h0,         1'b0, 32'd3, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0040_0208, 32'h0040_0204, 32'h0040_0208, 32'h2400_0204, 1'b1, 32'd4, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0040_01C8,  32'h0040_01C8, 32'h0,         32'h0,         32'h0,         1'b0, 32'd4, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0040_01C8, 32'h0040_01C8, 32'h0040_01CC, 32'h0810_0072, 1'b1, 32'd5, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0040_01C8, 32'h0,         32'h0,         32'h0,         1'b0, 32'd5, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h0040_01C8,  32'h0040_01C8, 32'h0,         32'h0,         32'h0,         1'b0, 32'd5, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h0040_0000,  32'h0040_0000, 32'h0,         32'h0,         32'h0,         1'b0, 32'd5, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 32'h2008_0000, 1'b1, 32'd6, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0,         32'h0,         32'h0,         1'b0, 32'd6, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h2400_FFFC, 1'b1, 32'd7, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 32'h2400_0000, 1'b1, 32'd8, 1'b0};

    // Reset for two cycles
    step; step;
    chk("rst if_valid", {31'd0, if_valid_o}, 32'd0);
    chk("rst if_pc", if_pc_o, 32'd0);
    chk("rst count", fetch_count_o, 32'd0);
    chk("rst halted", {31'd0, halted_o}, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("boot addr", imem_addr_o, 32'h0040_0000);
    chk("boot valid", {31'd0, if_valid_o}, 32'd0);
    step;  // BOOT -> RUN, nothing captured
    chk("boot->run valid", {31'd0, if_valid_o}, 32'd0);
    chk("boot->run addr", imem_addr_o, 32'h0040_0000);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].flush, vecs[i].redir, vecs[i].rpc);
      step;
      chk($sformatf("v%0d addr", i), imem_addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d if_pc", i), if_pc_o, vecs[i].e_pc);
      chk($sformatf("v%0d if_pc4", i), if_pc4_o, vecs[i].e_pc4);
      chk($sformatf("v%0d if_inst", i), if_inst_o, vecs[i].e_inst);
      chk($sformatf("v%0d if_valid", i), {31'd0, if_valid_o}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d count", i), fetch_count_o, vecs[i].e_cnt);
      chk($sformatf("v%0d halted", i), {31'd0, halted_o}, {31'd0, vecs[i].e_halt});
    end

`ifdef DBG_PORT_EN
    @(negedge clk); drive(1'b0, 1'b0, 1'b1, 32'h0040_01C8); step;
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h0); step;
    chk("dbg halted", {31'd0, halted_o}, 32'd1);
    @(negedge clk);
    dbg_req_i = 1'b1; dbg_addr_i = 32'h0040_0130;
    #1;
    chk("dbg gnt", {31'd0, dbg_gnt_o}, 32'd1);
    chk("dbg addr", imem_addr_o, 32'h0040_0130);
    step;
    chk("dbg data", dbg_data_o, 32'h2008_0001);
    chk("dbg valid", {31'd0, dbg_valid_o}, 32'd1);
    @(negedge clk); dbg_req_i = 1'b0; drive(1'b0, 1'b0, 1'b1, 32'h0040_0000); step;
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h0); dbg_req_i = 1'b1;
    #1;
    chk("dbg gnt run", {31'd0, dbg_gnt_o}, 32'd0);
    @(negedge clk); dbg_req_i = 1'b0;
`endif

    // Counter saturation from a preloaded near-max value
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    force dut.fetch_count = 32'hFFFF_FFFE;
    #1;
    release dut.fetch_count;
    step;
    chk("sat count 1", fetch_count_o, 32'hFFFF_FFFF);
    chk("sat valid", {31'd0, if_valid_o}, 32'd1);
    step;
    chk("sat count 2", fetch_count_o, 32'hFFFF_FFFF);

    // Reset asserted in the middle of a stall
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h0); step;
    @(negedge clk); reset = 1'b1; step;
    chk("mid rst addr", imem_addr_o, 32'h0040_0000);
    chk("mid rst if_pc", if_pc_o, 32'd0);
    chk("mid rst if_pc4", if_pc4_o, 32'd0);
    chk("mid rst if_inst", if_inst_o, 32'd0);
    chk("mid rst valid", {31'd0, if_valid_o}, 32'd0);
    chk("mid rst count", fetch_count_o, 32'd0);
    chk("mid rst halted", {31'd0, halted_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
